ext_mode_sequencer: RTL and testbench

- Host-side driver for the matrix multiplier's external-mode port. It is the transmitting end of that interface and also captures its results.
- Accepts one weight tile and a job of N input vectors over valid/ready streams, then buffers them.
- Drives ext_inputs_o: ROW weight-load cycles, followed by a continuous valid burst including drain padding.
- Captures every result flagged by ext_valid_i into a result buffer, then returns results over a valid/ready stream.

---
 rtl/ext_mode_sequencer_if.sv | 49 ++++
 rtl/ext_mode_sequencer.sv | 239 +++++++++++++++++++++++
 tb/tb_ext_mode_sequencer.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ext_mode_sequencer_if.sv
// Stream and array-port signal bundle for ext_mode_sequencer; master is the sequencer side.
interface ext_mode_sequencer_if #(
    parameter int WIDTH   = 8,
    parameter int ROW     = 4,
    parameter int COL     = 4,
    parameter int MAX_LEN = 16
);
    localparam int LW = $clog2(MAX_LEN + 1);

    typedef struct packed {
        logic [ROW*WIDTH-1:0] ext_input;
        logic [COL*WIDTH-1:0] ext_weight;
        logic                 ext_weight_en;
        logic                 ext_valid;
    } external_inputs_struct;

    logic                  start_i;
    logic [LW-1:0]         len_i;
    logic                  w_valid_i;
    logic                  w_ready_o;
    logic [COL*WIDTH-1:0]  w_data_i;
    logic                  in_valid_i;
    logic                  in_ready_o;
    logic [ROW*WIDTH-1:0]  in_data_i;
    logic                  ext_en_o;
    external_inputs_struct ext_inputs_o;
    logic [COL*WIDTH-1:0]  ext_result_i;
    logic                  ext_valid_i;
    logic                  res_valid_o;
    logic                  res_ready_i;
    logic [COL*WIDTH-1:0]  res_data_o;
    logic                  busy_o;
    logic                  done_o;
    logic                  err_o;

    modport master (
        input  start_i, len_i, w_valid_i, w_data_i, in_valid_i, in_data_i,
               ext_result_i, ext_valid_i, res_ready_i,
        output w_ready_o, in_ready_o, ext_en_o, ext_inputs_o,
               res_valid_o, res_data_o, busy_o, done_o, err_o
    );

    modport slave (
        output start_i, len_i, w_valid_i, w_data_i, in_valid_i, in_data_i,
               ext_result_i, ext_valid_i, res_ready_i,
        input  w_ready_o, in_ready_o, ext_en_o, ext_inputs_o,
               res_valid_o, res_data_o, busy_o, done_o, err_o
    );
endinterface

// File: rtl/ext_mode_sequencer.sv
// Host driver for the array external-mode port: buffers a weight tile + N vectors, loads, runs, captures, drains.
// Latency: ROW load + N+ROW-1 run + 1 flush cycles from LOAD entry to the first DRAIN cycle.
// Backpressure: weight/input/result are valid/ready streams; EXT_IN_SKEW_EN adds diagonal input skew.
module ext_mode_sequencer #(
    parameter int WIDTH   = 8,
    parameter int ROW     = 4,
    parameter int COL     = 4,
    parameter int MAX_LEN = 16
) (
    input logic                  clk_i,
    input logic                  rst_i,
    ext_mode_sequencer_if.master bus
);
    localparam int LW  = $clog2(MAX_LEN + 1);
    localparam int AW  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int WCW = $clog2(ROW + 1);
    localparam int WAW = (ROW > 1) ? $clog2(ROW) : 1;
    localparam int RW  = $clog2(MAX_LEN + ROW + 1);
    localparam int IW  = ROW * WIDTH;
    localparam int OW  = COL * WIDTH;

    typedef enum logic [2:0] {
        IDLE, GET_W, GET_IN, LOAD, RUN, FLUSH, DRAIN, DONE
    } state_t;

    state_t         state;
    logic [LW-1:0]  n_len;
    logic [LW-1:0]  in_cnt;
    logic [LW-1:0]  cap_cnt;
    logic [LW-1:0]  rd_ptr;
    logic [WCW-1:0] w_cnt;
    logic [RW-1:0]  run_cnt;

    logic [OW-1:0]  w_mem   [ROW];
    logic [IW-1:0]  in_mem  [MAX_LEN];
    logic [OW-1:0]  res_mem [MAX_LEN];

    logic           w_rdy;
    logic           in_rdy;
    logic           ext_en;
    logic           x_wen;
    logic           x_valid;
    logic [IW-1:0]  x_input;
    logic [OW-1:0]  x_weight;
    logic           res_vld;
    logic [OW-1:0]  res_dat;
    logic           busy;
    logic           done;
    logic           err;

    logic [WCW-1:0] w_nxt;
    logic [RW-1:0]  run_nxt;
    logic [RW-1:0]  run_last;
    logic [LW-1:0]  rd_nxt;
    logic [LW-1:0]  cap_fin;
    logic           capturing;
    logic           cap_take;
    logic           cap_over;
    logic [IW-1:0]  ext_input_drv;

    assign w_nxt     = w_cnt + WCW'(1);
    assign run_nxt   = run_cnt + RW'(1);
    assign run_last  = RW'(n_len) + RW'(ROW - 2);
    assign rd_nxt    = rd_ptr + LW'(1);
    assign capturing = (state == RUN) || (state == FLUSH);
    assign cap_take  = capturing && bus.ext_valid_i && (cap_cnt < n_len);
    assign cap_over  = capturing && bus.ext_valid_i && (cap_cnt >= n_len);
    assign cap_fin   = cap_cnt + LW'(cap_take);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            n_len    <= '0;
            in_cnt   <= '0;
            cap_cnt  <= '0;
            rd_ptr   <= '0;
            w_cnt    <= '0;
            run_cnt  <= '0;
            w_rdy    <= 1'b0;
            in_rdy   <= 1'b0;
            ext_en   <= 1'b0;
            x_wen    <= 1'b0;
            x_valid  <= 1'b0;
            x_input  <= '0;
            x_weight <= '0;
            res_vld  <= 1'b0;
            res_dat  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start_i) begin
                        err     <= 1'b0;
                        busy    <= 1'b1;
                        w_cnt   <= '0;
                        in_cnt  <= '0;
                        run_cnt <= '0;
                        cap_cnt <= '0;
                        rd_ptr  <= '0;
                        if (bus.len_i == '0) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            n_len <= (bus.len_i > LW'(MAX_LEN)) ? LW'(MAX_LEN) : bus.len_i;
                            w_rdy <= 1'b1;
                            state <= GET_W;
                        end
                    end
                end
                GET_W: begin
                    if (bus.w_valid_i && w_rdy) begin
                        if (w_cnt == WCW'(ROW - 1)) begin
                            w_cnt  <= '0;
                            w_rdy  <= 1'b0;
                            in_rdy <= 1'b1;
                            state  <= GET_IN;
                        end else begin
                            w_cnt <= w_nxt;
                        end
                    end
                end
                GET_IN: begin
                    if (bus.in_valid_i && in_rdy) begin
                        in_cnt <= in_cnt + LW'(1);
                        if (in_cnt == n_len - LW'(1)) begin
                            in_rdy   <= 1'b0;
                            ext_en   <= 1'b1;
                            x_wen    <= 1'b1;
                            x_weight <= w_mem[0];
                            state    <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (w_cnt == WCW'(ROW - 1)) begin
                        x_wen    <= 1'b0;
                        x_weight <= '0;
                        x_valid  <= 1'b1;
                        x_input  <= in_mem[0];
                        run_cnt  <= '0;
                        state    <= RUN;
                    end else begin
                        w_cnt    <= w_nxt;
                        x_weight <= w_mem[w_nxt[WAW-1:0]];
                    end
                end
                RUN: begin
                    cap_cnt <= cap_fin;
                    if (cap_over) err <= 1'b1;
                    if (run_cnt == run_last) begin
                        x_valid <= 1'b0;
                        x_input <= '0;
                        state   <= FLUSH;
                    end else begin
                        run_cnt <= run_nxt;
                        // Past the last vector the lanes carry zero padding so the array drains.
                        x_input <= (run_nxt < RW'(n_len)) ? in_mem[run_nxt[AW-1:0]] : '0;
                    end
                end
                FLUSH: begin
                    cap_cnt <= cap_fin;
                    ext_en  <= 1'b0;
                    state   <= DRAIN;
                    if (cap_over || (cap_fin != n_len)) err <= 1'b1;
                    if (cap_fin != '0) begin
                        res_vld <= 1'b1;
                        // A result landing now in slot 0 is not readable from memory yet.
                        res_dat <= (cap_cnt == '0) ? bus.ext_result_i : res_mem[0];
                    end
                end
                DRAIN: begin
                    if (cap_cnt == '0) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (res_vld && bus.res_ready_i) begin
                        rd_ptr <= rd_nxt;
                        if (rd_nxt == cap_cnt) begin
                            res_vld <= 1'b0;
                            res_dat <= '0;
                            done    <= 1'b1;
                            state   <= DONE;
                        end else begin
                            res_dat <= res_mem[rd_nxt[AW-1:0]];
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Payload storage carries no reset; validity is tracked by the counters above.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (state == GET_W && w_rdy && bus.w_valid_i)
                w_mem[w_cnt[WAW-1:0]] <= bus.w_data_i;
            if (state == GET_IN && in_rdy && bus.in_valid_i)
                in_mem[in_cnt[AW-1:0]] <= bus.in_data_i;
            if (cap_take)
                res_mem[cap_cnt[AW-1:0]] <= bus.ext_result_i;
        end
    end

`ifdef EXT_IN_SKEW_EN
    // Lane r passes through r zero-reset stages, so vector i lane r lands on RUN cycle i+r.
    assign ext_input_drv[WIDTH-1:0] = x_input[WIDTH-1:0];
    for (genvar r = 1; r < ROW; r++) begin : g_skew
        logic [WIDTH-1:0] sr [r];
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                for (int j = 0; j < r; j++) sr[j] <= '0;
            end else begin
                sr[0] <= x_input[r*WIDTH +: WIDTH];
                for (int j = 1; j < r; j++) sr[j] <= sr[j-1];
            end
        end
        assign ext_input_drv[r*WIDTH +: WIDTH] = sr[r-1];
    end
`else
    assign ext_input_drv = x_input;
`endif

    assign bus.w_ready_o    = w_rdy;
    assign bus.in_ready_o   = in_rdy;
    assign bus.ext_en_o     = ext_en;
    assign bus.ext_inputs_o = {ext_input_drv, x_weight, x_wen, x_valid};
    assign bus.res_valid_o  = res_vld;
    assign bus.res_data_o   = res_dat;
    assign bus.busy_o       = busy;
    assign bus.done_o       = done;
    assign bus.err_o        = err;
endmodule

// File: tb/tb_ext_mode_sequencer.sv
// Directed bench for ext_mode_sequencer with a behavioural array stub on the external port.
`timescale 1ns/1ps
module tb_ext_mode_sequencer;
    localparam int W       = 8;
    localparam int ROW     = 4;
    localparam int COL     = 4;
    localparam int MAX_LEN = 16;
    localparam int LW      = $clog2(MAX_LEN + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ext_mode_sequencer_if #(.WIDTH(W), .ROW(ROW), .COL(COL), .MAX_LEN(MAX_LEN)) bus ();

    ext_mode_sequencer #(.WIDTH(W), .ROW(ROW), .COL(COL), .MAX_LEN(MAX_LEN)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    int drop_idx = -1;
    int exp_n;
    logic [COL*W-1:0] wts     [ROW];
    logic [ROW*W-1:0] vecs    [MAX_LEN];
    logic [COL*W-1:0] exp_res [MAX_LEN];

    function automatic logic [COL*W-1:0] res_pat(input int k);
        logic [COL*W-1:0] v;
        for (int c = 0; c < COL; c++) v[c*W +: W] = W'(k + 64 * c + 1);
        return v;
    endfunction

    function automatic logic [ROW*W-1:0] exp_in(input int c, input int n);
        logic [ROW*W-1:0] v;
        int i;
        v = '0;
        for (int r = 0; r < ROW; r++) begin
`ifdef EXT_IN_SKEW_EN
            i = c - r;
`else
            i = c;
`endif
            if (i >= 0 && i < n) v[r*W +: W] = vecs[i][r*W +: W];
        end
        return v;
    endfunction

    // Array stub: answers the ROW-th and later consecutive ext_valid cycles, one cycle late.
    initial begin
        int vcnt;
        logic pend;
        logic [COL*W-1:0] pend_dat;
        vcnt = 0;
        pend = 1'b0;
        pend_dat = '0;
        bus.ext_valid_i  = 1'b0;
        bus.ext_result_i = '0;
        forever begin
            @(negedge clk);
            bus.ext_valid_i  = pend;
            bus.ext_result_i = pend_dat;
            pend = 1'b0;
            if (bus.ext_inputs_o.ext_valid) begin
                if (vcnt >= ROW - 1) begin
                    pend     = ((vcnt - (ROW - 1)) != drop_idx);
                    pend_dat = res_pat(vcnt - (ROW - 1));
                end
                vcnt++;
            end else begin
                vcnt = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ext_en"}, bus.ext_en_o, 0);
        chk({tag, "_ext_input"}, bus.ext_inputs_o.ext_input, 0);
        chk({tag, "_ext_weight"}, bus.ext_inputs_o.ext_weight, 0);
        chk({tag, "_ext_wen"}, bus.ext_inputs_o.ext_weight_en, 0);
        chk({tag, "_ext_valid"}, bus.ext_inputs_o.ext_valid, 0);
        chk({tag, "_w_ready"}, bus.w_ready_o, 0);
        chk({tag, "_in_ready"}, bus.in_ready_o, 0);
        chk({tag, "_res_valid"}, bus.res_valid_o, 0);
        chk({tag, "_res_data"}, bus.res_data_o, 0);
        chk({tag, "_busy"}, bus.busy_o, 0);
        chk({tag, "_done"}, bus.done_o, 0);
        chk({tag, "_err"}, bus.err_o, 0);
    endtask

    task automatic do_start(input int len);
        bus.start_i = 1'b1;
        bus.len_i   = LW'(len);
        tick();
        bus.start_i = 1'b0;
        bus.len_i   = '0;
        chk("start_busy", bus.busy_o, 1);
        chk("start_err_clr", bus.err_o, 0);
        chk("start_w_ready", bus.w_ready_o, 1);
    endtask

    task automatic send_w();
        for (int k = 0; k < ROW; k++) begin
            if (k == 1) begin
                bus.w_valid_i = 1'b0;
                tick();
            end
            bus.w_valid_i = 1'b1;
            bus.w_data_i  = wts[k];
            chk("w_ready", bus.w_ready_o, 1);
            tick();
        end
        bus.w_valid_i = 1'b0;
    endtask

    task automatic send_in(input int n);
        for (int i = 0; i < n; i++) begin
            if (i == 2) begin
                bus.in_valid_i = 1'b0;
                tick();
            end
            bus.in_valid_i = 1'b1;
            bus.in_data_i  = vecs[i];
            chk("in_ready", bus.in_ready_o, 1);
            tick();
        end
        bus.in_valid_i = 1'b0;
    endtask

    task automatic check_run(input int n);
        for (int k = 0; k < ROW; k++) begin
            chk("load_ext_en", bus.ext_en_o, 1);
            chk("load_wen", bus.ext_inputs_o.ext_weight_en, 1);
            chk("load_weight", bus.ext_inputs_o.ext_weight, wts[k]);
            chk("load_valid", bus.ext_inputs_o.ext_valid, 0);
            chk("load_input", bus.ext_inputs_o.ext_input, 0);
            tick();
        end
        for (int c = 0; c < n + ROW - 1; c++) begin
            chk("run_ext_en", bus.ext_en_o, 1);
            chk("run_valid", bus.ext_inputs_o.ext_valid, 1);
            chk("run_wen", bus.ext_inputs_o.ext_weight_en, 0);
            chk("run_input", bus.ext_inputs_o.ext_input, exp_in(c, n));
            tick();
        end
        chk("flush_ext_en", bus.ext_en_o, 1);
        chk("flush_valid", bus.ext_inputs_o.ext_valid, 0);
        chk("flush_wen", bus.ext_inputs_o.ext_weight_en, 0);
        tick();
        chk("drain_ext_en", bus.ext_en_o, 0);
    endtask

    task automatic drain_done(input int rmode, input logic exp_err);
        int got;
        int cyc;
        got = 0;
        cyc = 0;
        while (got < exp_n && cyc < 200) begin
            bus.res_ready_i = (rmode == 0) ? 1'b1 : ((cyc % 2) == 0);
            chk("res_valid", bus.res_valid_o, 1);
            chk("res_data", bus.res_data_o, exp_res[got]);
            tick();
            if (bus.res_ready_i) got++;
            cyc++;
        end
        bus.res_ready_i = 1'b0;
        chk("drain_count", got, exp_n);
        chk("done_pulse", bus.done_o, 1);
        chk("done_res_valid", bus.res_valid_o, 0);
        chk("done_busy", bus.busy_o, 1);
        chk("done_err", bus.err_o, exp_err);
        tick();
        chk("idle_done", bus.done_o, 0);
        chk("idle_busy", bus.busy_o, 0);
        chk("idle_err_hold", bus.err_o, exp_err);
    endtask

    task automatic run_job(input int len, input int drop, input int rmode);
        int n;
        n = (len > MAX_LEN) ? MAX_LEN : len;
        drop_idx = drop;
        exp_n = 0;
        for (int k = 0; k < n; k++) begin
            if (k != drop) begin
                exp_res[exp_n] = res_pat(k);
                exp_n++;
            end
        end
        do_start(len);
        send_w();
        send_in(n);
        check_run(n);
        chk("drain_err", bus.err_o, (exp_n != n));
        drain_done(rmode, (exp_n != n));
    endtask

    initial begin
        bus.start_i     = 1'b0;
        bus.len_i       = '0;
        bus.w_valid_i   = 1'b0;
        bus.w_data_i    = '0;
        bus.in_valid_i  = 1'b0;
        bus.in_data_i   = '0;
        bus.res_ready_i = 1'b0;

        rst = 1'b1;
        tick();
        tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        // Weight beats 0x01..0x04, three input vectors, always-ready result sink.
        for (int k = 0; k < ROW; k++) wts[k] = {COL{W'(k + 1)}};
        for (int i = 0; i < 3; i++) vecs[i] = 32'hA0B0C0D0 + 32'h01010101 * (i + 1);
        run_job(3, -1, 0);

        // Full-depth job with a result sink that stalls every other cycle.
        for (int k = 0; k < ROW; k++) wts[k] = $urandom;
        for (int i = 0; i < MAX_LEN; i++) vecs[i] = $urandom;
        run_job(MAX_LEN, -1, 1);

        // One missing array result: short drain and a sticky error.
        for (int i = 0; i < 4; i++) vecs[i] = 32'h11111111 * (i + 1);
        run_job(4, 1, 0);

        // Reset on RUN cycle 2 of a fresh job; its start also clears the error.
        drop_idx = -1;
        do_start(3);
        send_w();
        send_in(3);
        for (int k = 0; k < ROW + 2; k++) tick();
        chk("midrun_valid", bus.ext_inputs_o.ext_valid, 1);
        rst = 1'b1;
        tick();
        chk_all_zero("midrun_reset");
        rst = 1'b0;
        for (int i = 0; i < 2; i++) vecs[i] = 32'h5A5A0000 + i;
        run_job(2, -1, 0);

        // Zero-length job.
        bus.start_i = 1'b1;
        bus.len_i   = '0;
        tick();
        bus.start_i = 1'b0;
        chk("zero_done", bus.done_o, 1);
        chk("zero_busy", bus.busy_o, 1);
        chk("zero_ext_en", bus.ext_en_o, 0);
        chk("zero_w_ready", bus.w_ready_o, 0);
        chk("zero_in_ready", bus.in_ready_o, 0);
        tick();
        chk("zero_done_end", bus.done_o, 0);
        chk("zero_busy_end", bus.busy_o, 0);
        chk("zero_w_ready_end", bus.w_ready_o, 0);

        // Oversized length clamps to the buffer depth.
        for (int i = 0; i < MAX_LEN; i++) vecs[i] = $urandom;
        run_job(MAX_LEN + 4, -1, 1);

        // Single vector whose lanes differ, showing per-lane placement.
        vecs[0] = 32'h44332211;
        run_job(1, -1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
